// File: rtl/prog_loader.sv
// Loads an ASCII program stream into instruction memory, keeping only the eight opcodes,
// checking bracket nesting and capacity, then releasing the processor from reset.
module prog_loader #(
  parameter logic [7:0] TERM      = 8'h00,
  parameter logic [7:0] DEPTH_MAX = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_load,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       proc_reset_,
  output logic [7:0] prog_len,
  output logic       load_done,
  output logic [1:0] err_code
);

  localparam logic [7:0] OpInc   = 8'h2B;  // +
  localparam logic [7:0] OpDec   = 8'h2D;  // -
  localparam logic [7:0] OpRight = 8'h3E;  // >
  localparam logic [7:0] OpLeft  = 8'h3C;  // <
  localparam logic [7:0] OpOut   = 8'h2E;  // .
  localparam logic [7:0] OpIn    = 8'h2C;  // ,
  localparam logic [7:0] OpOpen  = 8'h5B;  // [
  localparam logic [7:0] OpClose = 8'h5D;  // ]

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrUnmatch  = 2'd1;
  localparam logic [1:0] ErrUnclosed = 2'd2;
  localparam logic [1:0] ErrOverflow = 2'd3;

  typedef enum logic [2:0] {StIdle, StLoad, StTermWr, StRun, StErr} state_e;

  state_e     state;
  logic [7:0] count;
  logic [7:0] depth;
  logic       accept;
  logic       is_op;

  assign prog_len = count;
  assign accept   = (state == StLoad) && in_valid && in_ready;

  always_comb begin
    is_op = 1'b0;
    unique case (in_byte)
      OpInc, OpDec, OpRight, OpLeft, OpOut, OpIn, OpOpen, OpClose: is_op = 1'b1;
      default: is_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      count       <= 8'd0;
      depth       <= 8'd0;
      in_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= 8'd0;
      imem_wdata  <= 8'd0;
      proc_reset_ <= 1'b0;
      load_done   <= 1'b0;
      err_code    <= ErrNone;
    end else if (start_load) begin
      // A byte accepted in this same cycle is dropped; an already registered write
      // was presented to memory during this cycle and is therefore complete.
      state       <= StLoad;
      count       <= 8'd0;
      depth       <= 8'd0;
      in_ready    <= 1'b1;
      imem_we     <= 1'b0;
      proc_reset_ <= 1'b0;
      load_done   <= 1'b0;
      err_code    <= ErrNone;
    end else begin
      imem_we <= 1'b0;
      case (state)
        StLoad: begin
          if (accept) begin
            if (in_byte == TERM) begin
              if (depth != 8'd0) begin
                state    <= StErr;
                in_ready <= 1'b0;
                err_code <= ErrUnclosed;
              end else begin
                state      <= StTermWr;
                in_ready   <= 1'b0;
                imem_we    <= 1'b1;
                imem_addr  <= count;
                imem_wdata <= TERM;
              end
            end else if (is_op) begin
              // Address 255 is reserved for the end marker.
              if (count == 8'hFF) begin
                state    <= StErr;
                in_ready <= 1'b0;
                err_code <= ErrOverflow;
              end else if ((in_byte == OpOpen) && (depth == DEPTH_MAX)) begin
                state    <= StErr;
                in_ready <= 1'b0;
                err_code <= ErrUnclosed;
              end else if ((in_byte == OpClose) && (depth == 8'd0)) begin
                state    <= StErr;
                in_ready <= 1'b0;
                err_code <= ErrUnmatch;
              end else begin
                imem_we    <= 1'b1;
                imem_addr  <= count;
                imem_wdata <= in_byte;
                count      <= count + 8'd1;
                if (in_byte == OpOpen) begin
                  depth <= depth + 8'd1;
                end else if (in_byte == OpClose) begin
                  depth <= depth - 8'd1;
                end
              end
            end
          end
        end
        StTermWr: begin
          state       <= StRun;
          proc_reset_ <= 1'b1;
          load_done   <= 1'b1;
        end
        default: begin
          // Idle, Run and Err hold until reset or start_load.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; a negedge monitor logs every memory write.
module tb_prog_loader;

  logic       clk;
  logic       reset;
  logic       start_load;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       proc_reset_;
  logic [7:0] prog_len;
  logic       load_done;
  logic [1:0] err_code;

  int total;
  int bad;

  logic [7:0] log_addr [0:1023];
  logic [7:0] log_data [0:1023];
  int         wr_count;

  prog_loader #(
    .TERM      (8'h00),
    .DEPTH_MAX (8'd255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_load  (start_load),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .proc_reset_ (proc_reset_),
    .prog_len    (prog_len),
    .load_done   (load_done),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial wr_count = 0;
  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_count < 1024) begin
        log_addr[wr_count] <= imem_addr;
        log_data[wr_count] <= imem_wdata;
      end
      wr_count <= wr_count + 1;
    end
  end

  // All tasks are entered and left at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycles(3);
    total++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, proc_reset_, prog_len, load_done, err_code}
        !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {in_ready, imem_we, imem_addr, imem_wdata, proc_reset_, prog_len, load_done,
                err_code});
    end
    reset = 1'b0;
    idle_cycles(2);
    total++;
    if ({in_ready, proc_reset_, load_done} !== 3'b000) begin
      bad++;
      $display("FAIL idle_outputs got=%b exp=000", {in_ready, proc_reset_, load_done});
    end
  endtask

  task automatic test_basic();
    logic [7:0] src [0:5];
    logic [7:0] exp_d [0:5];
    int base;
    src[0] = 8'h2B; src[1] = 8'h5B; src[2] = 8'h2D; src[3] = 8'h5D; src[4] = 8'h2E;
    src[5] = 8'h00;
    exp_d[0] = 8'h2B; exp_d[1] = 8'h5B; exp_d[2] = 8'h2D; exp_d[3] = 8'h5D; exp_d[4] = 8'h2E;
    exp_d[5] = 8'h00;
    base = wr_count;
    pulse_start();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready got=%b exp=1", in_ready);
    end
    for (int i = 0; i < 6; i++) send_byte(src[i]);
    // Now inside the TERM write cycle.
    total++;
    if ({imem_we, imem_addr, imem_wdata, proc_reset_} !== {1'b1, 8'd5, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL basic_term_wr got=%0h exp=%0h", {imem_we, imem_addr, imem_wdata, proc_reset_},
               {1'b1, 8'd5, 8'h00, 1'b0});
    end
    idle_cycles(1);
    total++;
    if ({proc_reset_, load_done, in_ready, imem_we, err_code} !== 6'b110000) begin
      bad++;
      $display("FAIL basic_run got=%b exp=110000", {proc_reset_, load_done, in_ready, imem_we,
               err_code});
    end
    idle_cycles(2);
    total++;
    if (prog_len !== 8'd5) begin
      bad++;
      $display("FAIL basic_prog_len got=%0d exp=5", prog_len);
    end
    total++;
    if (wr_count - base !== 6) begin
      bad++;
      $display("FAIL basic_write_count got=%0d exp=6", wr_count - base);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({log_addr[base+i], log_data[base+i]} !== {i[7:0], exp_d[i]}) begin
        bad++;
        $display("FAIL basic_write%0d got=%0h:%0h exp=%0h:%0h", i, log_addr[base+i],
                 log_data[base+i], i[7:0], exp_d[i]);
      end
    end
    total++;
    if (proc_reset_ !== 1'b1) begin
      bad++;
      $display("FAIL basic_run_hold got=%b exp=1", proc_reset_);
    end
  endtask

  task automatic test_filter();
    logic [7:0] src [0:6];
    int base;
    src[0] = 8'h61; src[1] = 8'h2B; src[2] = 8'h20; src[3] = 8'h62; src[4] = 8'h0A;
    src[5] = 8'h3E; src[6] = 8'h00;
    base = wr_count;
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(src[i]);
    idle_cycles(3);
    total++;
    if (wr_count - base !== 3) begin
      bad++;
      $display("FAIL filter_write_count got=%0d exp=3", wr_count - base);
    end
    total++;
    if ({log_addr[base], log_data[base], log_addr[base+1], log_data[base+1], log_addr[base+2],
         log_data[base+2]} !== {8'd0, 8'h2B, 8'd1, 8'h3E, 8'd2, 8'h00}) begin
      bad++;
      $display("FAIL filter_writes got=%0h exp=%0h", {log_addr[base], log_data[base],
               log_addr[base+1], log_data[base+1], log_addr[base+2], log_data[base+2]},
               {8'd0, 8'h2B, 8'd1, 8'h3E, 8'd2, 8'h00});
    end
    total++;
    if ({prog_len, load_done, proc_reset_} !== {8'd2, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL filter_status got=%0h exp=%0h", {prog_len, load_done, proc_reset_},
               {8'd2, 1'b1, 1'b1});
    end
  endtask

  task automatic test_unmatched();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h5D);
    idle_cycles(3);
    total++;
    if ({err_code, proc_reset_, load_done, in_ready} !== {2'd1, 3'b000}) begin
      bad++;
      $display("FAIL unmatched_status got=%b exp=01000", {err_code, proc_reset_, load_done,
               in_ready});
    end
    total++;
    if (wr_count - base !== 0) begin
      bad++;
      $display("FAIL unmatched_writes got=%0d exp=0", wr_count - base);
    end
  endtask

  task automatic test_unclosed();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h5B);
    send_byte(8'h5B);
    send_byte(8'h00);
    idle_cycles(3);
    total++;
    if ({err_code, proc_reset_, load_done, prog_len} !== {2'd2, 2'b00, 8'd2}) begin
      bad++;
      $display("FAIL unclosed_status got=%0h exp=%0h", {err_code, proc_reset_, load_done,
               prog_len}, {2'd2, 2'b00, 8'd2});
    end
    total++;
    if (wr_count - base !== 2) begin
      bad++;
      $display("FAIL unclosed_writes got=%0d exp=2", wr_count - base);
    end
    total++;
    if ({log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]}
        !== {8'd0, 8'h5B, 8'd1, 8'h5B}) begin
      bad++;
      $display("FAIL unclosed_data got=%0h exp=%0h", {log_addr[base], log_data[base],
               log_addr[base+1], log_data[base+1]}, {8'd0, 8'h5B, 8'd1, 8'h5B});
    end
  endtask

  task automatic test_overflow();
    int base;
    int wrong;
    int hit255;
    base   = wr_count;
    wrong  = 0;
    hit255 = 0;
    pulse_start();
    for (int i = 0; i < 256; i++) send_byte(8'h2B);
    idle_cycles(3);
    total++;
    if (wr_count - base !== 255) begin
      bad++;
      $display("FAIL overflow_write_count got=%0d exp=255", wr_count - base);
    end
    for (int i = 0; i < 255; i++) begin
      if ({log_addr[base+i], log_data[base+i]} !== {i[7:0], 8'h2B}) wrong++;
      if (log_addr[base+i] === 8'hFF) hit255++;
    end
    total++;
    if (wrong !== 0) begin
      bad++;
      $display("FAIL overflow_data got=%0d exp=0 wrong entries", wrong);
    end
    total++;
    if (hit255 !== 0) begin
      bad++;
      $display("FAIL overflow_addr255 got=%0d exp=0 writes", hit255);
    end
    total++;
    if ({err_code, prog_len, proc_reset_, in_ready} !== {2'd3, 8'hFF, 2'b00}) begin
      bad++;
      $display("FAIL overflow_status got=%0h exp=%0h", {err_code, prog_len, proc_reset_,
               in_ready}, {2'd3, 8'hFF, 2'b00});
    end
  endtask

  task automatic test_reset_midload();
    int base;
    in_valid = 1'b0;
    pulse_start();
    in_valid = 1'b1;
    in_byte  = 8'h2B;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    base = wr_count;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    total++;
    if (wr_count - base !== 0) begin
      bad++;
      $display("FAIL midreset_writes got=%0d exp=0", wr_count - base);
    end
    total++;
    if ({prog_len, in_ready, imem_we} !== 10'd0) begin
      bad++;
      $display("FAIL midreset_status got=%0h exp=0", {prog_len, in_ready, imem_we});
    end
    pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    idle_cycles(2);
    total++;
    if ((wr_count - base !== 1) ||
        ({log_addr[base], log_data[base]} !== {8'd0, 8'h2B})) begin
      bad++;
      $display("FAIL midreset_restart got=%0d:%0h exp=1:%0h", wr_count - base,
               {log_addr[base], log_data[base]}, {8'd0, 8'h2B});
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h2B);
    start_load = 1'b1;
    in_byte    = 8'h2D;
    @(negedge clk);
    start_load = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ((wr_count - base !== 1) ||
        ({log_addr[base], log_data[base]} !== {8'd0, 8'h2B})) begin
      bad++;
      $display("FAIL b2b_pending got=%0d:%0h exp=1:%0h", wr_count - base,
               {log_addr[base], log_data[base]}, {8'd0, 8'h2B});
    end
    total++;
    if ({prog_len, in_ready} !== {8'd0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_restart got=%0h exp=%0h", {prog_len, in_ready}, {8'd0, 1'b1});
    end
    send_byte(8'h3E);
    send_byte(8'h00);
    idle_cycles(2);
    total++;
    if ((wr_count - base !== 3) ||
        ({log_addr[base+1], log_data[base+1], log_addr[base+2], log_data[base+2]}
         !== {8'd0, 8'h3E, 8'd1, 8'h00})) begin
      bad++;
      $display("FAIL b2b_reload got=%0d:%0h exp=3:%0h", wr_count - base,
               {log_addr[base+1], log_data[base+1], log_addr[base+2], log_data[base+2]},
               {8'd0, 8'h3E, 8'd1, 8'h00});
    end
    total++;
    if ({prog_len, load_done, proc_reset_} !== {8'd1, 2'b11}) begin
      bad++;
      $display("FAIL b2b_status got=%0h exp=%0h", {prog_len, load_done, proc_reset_},
               {8'd1, 2'b11});
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    start_load = 1'b0;
    in_valid   = 1'b0;
    in_byte    = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_filter();
    test_unmatched();
    test_unclosed();
    test_overflow();
    test_reset_midload();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter TERM, default 8'h00, SHALL be the end-of-program byte value.
REQ-002 Parameter DEPTH_MAX, default 8'd255, SHALL be the maximum legal '[' nesting depth.
REQ-003 clk  in  1  single clock; every register SHALL update on its rising edge only.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start_load  in  1  single-cycle pulse that SHALL begin a new load.
REQ-006 in_valid  in  1  SHALL qualify in_byte as holding a source byte.
REQ-007 in_byte  in  8  SHALL carry the ASCII source byte.
REQ-008 in_ready  out  1  SHALL signal that the loader accepts in_byte this cycle.
REQ-009 imem_we  out  1  SHALL be the instruction-memory write enable.
REQ-010 imem_addr  out  8  SHALL be the instruction-memory write address.
REQ-011 imem_wdata  out  8  SHALL be the instruction-memory write data.
REQ-012 proc_reset_  out  1  SHALL drive the processor's active-low reset; 1 = run.
REQ-013 prog_len  out  8  SHALL give the number of opcodes stored.
REQ-014 load_done  out  1  SHALL indicate that the load finished without error.
REQ-015 err_code  out  2  SHALL report load errors: 0 none, 1 unmatched ']', 2 unclosed '[' or depth over DEPTH_MAX, 3 overflow.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, LOAD, TERM_WR, RUN and ERR.
REQ-017 IDLE SHALL move to LOAD on start_load; in IDLE, in_ready=0 and proc_reset_=0.
REQ-018 start_load in any state SHALL, on the next cycle, enter LOAD and set count=0, depth=0, err_code=0, load_done=0 and proc_reset_=0.
REQ-019 In LOAD, in_ready SHALL be 1; a byte SHALL be accepted only when in_valid and in_ready are both 1.
REQ-020 An accepted byte that is one of the opcodes > < + - . , [ ] SHALL be written to imem_addr=count on the cycle after acceptance (imem_we=1 for one cycle), and count SHALL then increment.
REQ-021 An accepted byte that is neither an opcode nor TERM SHALL be discarded: no write, count unchanged.
REQ-022 An accepted '[' SHALL increment depth; if depth would exceed DEPTH_MAX, the FSM SHALL go to ERR with err_code=2 and perform no write.
REQ-023 An accepted ']' with depth=0 SHALL send the FSM to ERR with err_code=1 and perform no write; otherwise depth SHALL decrement.
REQ-024 An accepted opcode while count=255 SHALL send the FSM to ERR with err_code=3 and perform no write, because address 255 is reserved for the end marker.
REQ-025 An accepted TERM SHALL go to ERR with err_code=2 if depth≠0; otherwise the FSM SHALL go to TERM_WR.
REQ-026 TERM_WR SHALL last one cycle and write TERM at imem_addr=count; the FSM SHALL then enter RUN.
REQ-027 In RUN, proc_reset_=1, load_done=1 and in_ready=0; RUN SHALL be held until reset or start_load.
REQ-028 In ERR, proc_reset_=0, in_ready=0 and load_done=0; err_code SHALL be held until reset or start_load.
REQ-029 prog_len SHALL equal count at all times.
REQ-030 imem_we SHALL be 0 in every state except the write cycles defined in REQ-020 and REQ-026.
REQ-031 The count and depth arithmetic SHALL be 8-bit and SHALL never wrap, because the errors in REQ-022 and REQ-024 pre-empt wrapping.
REQ-032 When start_load and an accepted byte occur in the same cycle, start_load SHALL win and the byte SHALL be dropped.
REQ-033 If acceptance of a byte and a start_load fall on consecutive cycles, the pending write SHALL still complete at the old address.

Reset
REQ-034 When reset=1, the next state SHALL be IDLE, overriding start_load.
REQ-035 Reset values SHALL be: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, proc_reset_=0, prog_len=0, load_done=0, err_code=0, count=0, depth=0.
REQ-036 Reset asserted mid-load SHALL abort the load with no further writes; memory contents are don't-care.

Verification
REQ-037 Load "+[-]." followed by TERM -> writes 2B,5B,2D,5D,2E at addresses 0-4 and 00 at address 5; prog_len=5; proc_reset_ rises 1 cycle after the TERM write; err_code=0.
REQ-038 Load "a+ b\n>" followed by TERM -> only 2B at 0 and 3E at 1, then 00 at 2; prog_len=2.
REQ-039 Load "]" -> ERR, err_code=1, no write, proc_reset_ stays 0.
REQ-040 Load "[[" followed by TERM -> ERR, err_code=2, and no TERM write at address 2.
REQ-041 Load 256 '+' bytes -> addresses 0-254 written; the 256th byte gives err_code=3 and address 255 is never written.
REQ-042 Hold in_valid=1 throughout, assert reset on the 3rd byte, then pulse start_load -> no write after reset, count=0, and the new load starts at address 0.
